// File: rtl/split_sched.sv
// split_sched: pulls words from one source FIFO and deals them out to two
// sinks in bursts of stage_r words, alternating channels, until num_r words
// have been delivered. One word in flight at a time: FETCH -> CAPTURE -> PUSH.
module split_sched #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   cfg_num,
  input  logic [31:0]   cfg_stagecnt,
  input  logic          idata_rdy,
  input  logic [DW-1:0] idata,
  output logic          idata_pop,
  input  logic          odata1_rdy,
  input  logic          odata2_rdy,
  output logic          odata1_push,
  output logic          odata2_push,
  output logic [DW-1:0] odata1,
  output logic [DW-1:0] odata2,
  output logic          busy,
  output logic          done,
  output logic          chan_sel,
  output logic [31:0]   xfer_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PUSH    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   num_q,   num_d;
  logic [31:0]   stage_q, stage_d;
  logic [31:0]   xfer_q,  xfer_d;
  logic [31:0]   burst_q, burst_d;
  logic          chan_q,  chan_d;
  logic [DW-1:0] data_q,  data_d;

  logic [31:0]   xfer_inc, burst_inc;
  logic          sel_rdy;

  assign xfer_inc  = xfer_q + 32'd1;
  assign burst_inc = burst_q + 32'd1;
  assign sel_rdy   = chan_q ? odata2_rdy : odata1_rdy;

  // State and datapath registers; reset drops any job in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      stage_q <= '0;
      xfer_q  <= '0;
      burst_q <= '0;
      chan_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      stage_q <= stage_d;
      xfer_q  <= xfer_d;
      burst_q <= burst_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
    end
  end

  // Next-state, counter updates and strobes. abort wins over everything in
  // the busy states and leaves the counters where they are.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    stage_d     = stage_q;
    xfer_d      = xfer_q;
    burst_d     = burst_q;
    chan_d      = chan_q;
    data_d      = data_q;
    idata_pop   = 1'b0;
    odata1_push = 1'b0;
    odata2_push = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = cfg_num;
          // a zero burst length would never switch channel; treat it as 1
          stage_d = (cfg_stagecnt == 32'd0) ? 32'd1 : cfg_stagecnt;
          xfer_d  = '0;
          burst_d = '0;
          chan_d  = 1'b0;
          state_d = (cfg_num == 32'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idata_rdy) begin
          idata_pop = 1'b1;
          state_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // the popped word is only taken if the job survives this cycle
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          data_d  = idata;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (sel_rdy) begin
          odata1_push = ~chan_q;
          odata2_push = chan_q;
          xfer_d      = xfer_inc;
          if (burst_inc == stage_q) begin
            burst_d = '0;
            chan_d  = ~chan_q;
          end else begin
            burst_d = burst_inc;
          end
          state_d = (xfer_inc == num_q) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == S_FETCH) || (state_q == S_CAPTURE) || (state_q == S_PUSH);
  assign done     = (state_q == S_DONE);
  assign chan_sel = chan_q;
  assign xfer_cnt = xfer_q;
  assign odata1   = data_q;
  assign odata2   = data_q;

endmodule

// File: doc/split_sched.md
SPLIT_SCHED -- requirements
Module: split_sched

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all state on rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-003 SHALL have ports: start  input  1  one-cycle job request; sampled only in IDLE.
REQ-004 SHALL have ports: abort  input  1  terminate job; return to IDLE.
REQ-005 SHALL have ports: cfg_num  input  32  total words per job.
REQ-006 SHALL have ports: cfg_stagecnt  input  32  burst length per channel before switching.
REQ-007 SHALL have ports: idata_rdy  input  1  source FIFO non-empty.
REQ-008 SHALL have ports: idata  input  32  source FIFO read data, valid the cycle after idata_pop.
REQ-009 SHALL have ports: idata_pop  output  1  source FIFO pop strobe.
REQ-010 SHALL have ports: odata1_rdy / odata2_rdy  input  1 each  sink can accept.
REQ-011 SHALL have ports: odata1_push / odata2_push  output  1 each  sink write strobe.
REQ-012 SHALL have ports: odata1 / odata2  output  32 each  both driven from one data register.
REQ-013 SHALL have ports: busy  output  1, done  output  1, chan_sel  output  1 (0 = channel 1), xfer_cnt  output  32.

Function
REQ-014 SHALL implement states IDLE, FETCH, CAPTURE, PUSH, DONE.
REQ-015 IDLE: busy=0. On start=1, latch cfg_num to num_r and max(cfg_stagecnt,1) to stage_r; clear xfer_cnt, burst_cnt, chan_sel. Go to DONE if cfg_num==0, else FETCH.
REQ-016 FETCH: idata_pop = idata_rdy, combinational, this state only. If idata_rdy, go to CAPTURE; else stay.
REQ-017 CAPTURE: data_r <= idata; go to PUSH. No pop or push in this state.
REQ-018 PUSH: when chan_sel=0, odata1_push = odata1_rdy; when chan_sel=1, odata2_push = odata2_rdy.
REQ-019 PUSH while the selected channel is not ready: hold state and data_r, with no strobes.
REQ-020 On an accepted push: xfer_cnt+1 and burst_cnt+1.
REQ-021 On an accepted push where burst_cnt+1 == stage_r: burst_cnt <= 0 and chan_sel toggles.
REQ-022 After an accepted push, go to DONE if xfer_cnt+1 == num_r, else FETCH.
REQ-023 DONE: done=1 for exactly one cycle; busy=0; go to IDLE. xfer_cnt and chan_sel hold until the next start.
REQ-024 busy=1 in FETCH, CAPTURE and PUSH.
REQ-025 Minimum per-word latency is 3 cycles (FETCH, CAPTURE, PUSH). At most one push per cycle; the two push strobes are never asserted together.
REQ-026 start outside IDLE SHALL be ignored. cfg_* changes during a job SHALL have no effect.
REQ-027 abort has priority over all transitions in any busy state: no pop or push that cycle; next state IDLE; done not asserted; counters hold their values.
REQ-028 A word popped before an abort is discarded.
REQ-029 Counters are 32-bit unsigned. xfer_cnt cannot exceed num_r, so there is no wrap.
REQ-030 stage_r >= num_r SHALL send all words to channel 1.
REQ-031 odata1 and odata2 SHALL always equal data_r; they are meaningful only with the matching push strobe.

Reset
REQ-032 While rst=0: state=IDLE, and idata_pop, odata1_push, odata2_push, busy, done, chan_sel = 0.
REQ-033 While rst=0: xfer_cnt, burst_cnt, data_r, num_r, stage_r = 0.
REQ-034 Reset asserted mid-job SHALL abandon the job at once, with no further strobes and no done.
REQ-035 After reset the block SHALL require a fresh start.

Verification
REQ-036 cfg_num=6, cfg_stagecnt=2, both sinks always ready, FIFO always ready -> words W0,W1 on ch1, W2,W3 on ch2, W4,W5 on ch1; push every 3rd cycle; one-cycle done 1 cycle after last push; xfer_cnt=6.
REQ-037 cfg_num=0 -> done pulses the cycle after start; no pop, no push; busy never 1.
REQ-038 cfg_num=3, cfg_stagecnt=0 -> treated as 1; channels ch1, ch2, ch1; chan_sel=1 at done.
REQ-039 odata2_rdy held low 5 cycles during a ch2 burst -> block stays in PUSH; data_r stable; no pop; push on the first cycle rdy returns.
REQ-040 idata_rdy low in FETCH for 4 cycles, then abort in the following PUSH -> no extra pop; no push on the abort cycle; IDLE next cycle; done stays 0; a new start is accepted.
REQ-041 rst pulsed low mid-burst (asynchronous, between edges) -> all outputs 0 immediately; after release, start with cfg_num=1 completes normally.
